dcache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM-stage memory port and main data memory. On the processor side it returns read data and a `cpu_hit` flag; while `cpu_hit` is 0 the core's stall controller freezes the pipeline. On the memory side it performs 4-word line writebacks and fills through a one-word-per-cycle ready handshake.

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_if.sv | 28 ++
 rtl/dcache_data_array.sv | 24 ++
 rtl/dcache_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// DCACHE_UNCACHED_IO_EN adds the IO/IO_DONE bypass states to the FSM encoding.
package dcache_pkg;
  localparam int         ADDR_W         = 16;
  localparam int         DATA_W         = 16;
  localparam int         OFFSET_BITS    = 2;
  localparam int         WORDS_PER_LINE = 4;
  localparam logic [3:0] IO_REGION      = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL
`ifdef DCACHE_UNCACHED_IO_EN
    ,
    ST_IO,
    ST_IO_DONE
`endif
  } state_t;
endpackage

// File: rtl/dcache_if.sv
// CPU-side request/response and memory-side word-transfer signals of the data cache.
// slave is the cache controller; master is whoever drives requests and memory responses.
interface dcache_if;
  import dcache_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_re;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hit;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    output cpu_rdata, cpu_hit, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_wdata, mem_rdata, mem_rdy,
    input  cpu_rdata, cpu_hit, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/dcache_data_array.sv
// Cache line data storage: combinational read, one synchronous write port.
// Read latency 0, write visible the cycle after wr_en; no flow control.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                              clk,
  input  logic [INDEX_BITS+OFFSET_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  input  logic                              wr_en,
  input  logic [INDEX_BITS+OFFSET_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]                 wr_data
);
  localparam int DEPTH = WORDS_PER_LINE << INDEX_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate cache: hits in 0 cycles, misses stall via cpu_hit=0
// while 4-word WB/FILL bursts advance on mem_rdy. Optional DCACHE_UNCACHED_IO_EN bypasses 0xF region.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);
  localparam int TAG_BITS = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(WORDS_PER_LINE - 1);

  logic [TAG_BITS-1:0]    tag_q [LINES];
  logic [LINES-1:0]       valid_q, dirty_q;
  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q;
  logic [TAG_BITS-1:0]    miss_tag_q;
  logic [INDEX_BITS-1:0]  miss_idx_q;

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic req, tag_hit, is_io, cache_miss, hit_wr, fill_wr, fill_done;

  assign {req_tag, req_idx, req_off} = bus.cpu_addr;
  assign req     = bus.cpu_re | bus.cpu_we;
  assign tag_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
`ifdef DCACHE_UNCACHED_IO_EN
  assign is_io   = (bus.cpu_addr[ADDR_W-1 -: 4] == IO_REGION);
`else
  assign is_io   = 1'b0;
`endif

  assign cache_miss = (state_q == ST_IDLE) && req && !is_io && !tag_hit;
  assign hit_wr     = (state_q == ST_IDLE) && bus.cpu_we && !is_io && tag_hit;
  assign fill_wr    = (state_q == ST_FILL) && bus.mem_rdy;
  assign fill_done  = fill_wr && (cnt_q == LAST_WORD);

  logic [INDEX_BITS+OFFSET_BITS-1:0] arr_raddr, arr_waddr;
  logic [DATA_W-1:0]                 arr_rdata;

  // The single read port serves CPU hits in IDLE and the victim words during WB.
  assign arr_raddr = (state_q == ST_WB) ? {miss_idx_q, cnt_q} : {req_idx, req_off};
  assign arr_waddr = fill_wr ? {miss_idx_q, cnt_q} : {req_idx, req_off};

  dcache_data_array #(.INDEX_BITS(INDEX_BITS)) u_data (
    .clk     (clk),
    .rd_addr (arr_raddr),
    .rd_data (arr_rdata),
    .wr_en   (!rst && (fill_wr || hit_wr)),
    .wr_addr (arr_waddr),
    .wr_data (fill_wr ? bus.mem_rdata : bus.cpu_wdata)
  );

`ifdef DCACHE_UNCACHED_IO_EN
  logic [ADDR_W-1:0] io_addr_q;
  logic              io_we_q;
  logic [DATA_W-1:0] io_wdata_q, io_rdata_q;

  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && req && is_io) begin
      io_addr_q  <= bus.cpu_addr;
      io_we_q    <= bus.cpu_we;
      io_wdata_q <= bus.cpu_wdata;
    end
    if ((state_q == ST_IO) && bus.mem_rdy) io_rdata_q <= bus.mem_rdata;
  end
`endif

  logic              hit_c, mre_c, mwe_c;
  logic [DATA_W-1:0] rdata_c, mwdata_c;
  logic [ADDR_W-1:0] maddr_c;

  always_comb begin
    state_d  = state_q;
    hit_c    = 1'b0;
    rdata_c  = arr_rdata;
    mre_c    = 1'b0;
    mwe_c    = 1'b0;
    maddr_c  = '0;
    mwdata_c = '0;
    case (state_q)
      ST_IDLE: begin
        hit_c = !req || (tag_hit && !is_io);
        if (cache_miss) state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? ST_WB : ST_FILL;
`ifdef DCACHE_UNCACHED_IO_EN
        if (req && is_io) state_d = ST_IO;
`endif
      end
      ST_WB: begin
        mwe_c    = 1'b1;
        maddr_c  = {tag_q[miss_idx_q], miss_idx_q, cnt_q};
        mwdata_c = arr_rdata;
        if (bus.mem_rdy && (cnt_q == LAST_WORD)) state_d = ST_FILL;
      end
      ST_FILL: begin
        mre_c   = 1'b1;
        maddr_c = {miss_tag_q, miss_idx_q, cnt_q};
        if (fill_done) state_d = ST_IDLE;
      end
`ifdef DCACHE_UNCACHED_IO_EN
      ST_IO: begin
        mre_c    = !io_we_q;
        mwe_c    = io_we_q;
        maddr_c  = io_addr_q;
        mwdata_c = io_we_q ? io_wdata_q : '0;
        if (bus.mem_rdy) state_d = ST_IO_DONE;
      end
      ST_IO_DONE: begin
        hit_c   = 1'b1;
        rdata_c = io_rdata_q;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_hit   = hit_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_re    = mre_c;
  assign bus.mem_we    = mwe_c;
  assign bus.mem_addr  = maddr_c;
  assign bus.mem_wdata = mwdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (cache_miss) cnt_q <= '0;
      else if (((state_q == ST_WB) || (state_q == ST_FILL)) && bus.mem_rdy) cnt_q <= cnt_q + 1'b1;
      if (hit_wr) dirty_q[req_idx] <= 1'b1;
      // The tag only changes on the last fill word, so an interrupted fill never looks valid.
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_done) tag_q[miss_idx_q] <= miss_tag_q;
    if (!rst && cache_miss) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
    end
  end
endmodule
